// File: rtl/div_unit.sv
// RV32M divide/remainder: 32-step restoring division, one 33-bit subtract per step.
// Latency: done 33 cycles after accepted start (1 cycle for divide-by-zero/overflow).
// Backpressure: busy high during CALC; start is ignored while busy, accepted in IDLE/DONE.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] rem, quo, bmag;
    logic [CW-1:0]   cnt;
    logic            is_rem_q, neg_q, neg_r;

    logic            accept;
    logic            in_signed, in_is_rem;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow, special;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic [XLEN-1:0] final_q, final_r;

    assign accept    = start && (state == IDLE || state == DONE);
    assign in_signed = ~op[0];
    assign in_is_rem = op[1];
    assign a_mag     = (in_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (in_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    assign div_zero  = (b == '0);
    assign overflow  = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special   = div_zero || overflow;

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    assign diff = {rem, quo[XLEN-1]} - {1'b0, bmag};

    always_comb begin
        rem_nx = '0;
        quo_nx = '0;
        if (!diff[XLEN]) begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = {rem[XLEN-2:0], quo[XLEN-1]};
            quo_nx = {quo[XLEN-2:0], 1'b0};
        end
    end

    assign final_q = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    assign final_r = neg_r ? (~rem_nx + 1'b1) : rem_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = special ? DONE : CALC;
            CALC: if (cnt == LAST_CNT) state_nx = DONE;
            DONE: begin
                if (start) state_nx = special ? DONE : CALC;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            bmag     <= '0;
            cnt      <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            is_rem_q <= in_is_rem;
            neg_q    <= in_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r    <= in_signed && a[XLEN-1];
            bmag     <= b_mag;
            if (div_zero) begin
                result <= in_is_rem ? a : '1;
            end else if (overflow) begin
                result <= in_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                rem <= '0;
                quo <= a_mag;
                cnt <= '0;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT)
                result <= is_rem_q ? final_r : final_q;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: normal, signed, special-case, ignored-start, back-to-back and reset-abort.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("comparison %s did not hold", tag);
        end
    endtask

    // Drives start across edge T, scrambles operands afterwards, returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        @(negedge clk);
    endtask

    // Checks busy over T+1..T+32 then done/result at T+33 (or T+1 when special); ends in the done cycle.
    task automatic wait_done(input string tag, input bit special, input logic [31:0] exp);
        if (!special) begin
            for (int i = 1; i <= 32; i++) begin
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
                check({tag, "_nodone"}, {31'd0, done}, 32'd0);
                @(negedge clk);
            end
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit special, input logic [31:0] exp);
        issue(o, x, y);
        wait_done(tag, special, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd14);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0, 32'd2);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1);

        run_op("divu_z", OP_DIVU, 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF);
        run_op("div_z",  OP_DIV,  32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF);
        run_op("remu_z", OP_REMU, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);
        run_op("rem_z",  OP_REM,  32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);

        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
        run_op("divu_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // start pulsed mid-CALC at T+10 must be ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        start = 1'b1; op = OP_REMU; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 10; i <= 32; i++) begin
            check("ign_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_result", result, 32'd14);
        @(negedge clk);
        check("ign_single", {31'd0, done}, 32'd0);
        repeat (40) begin
            check("ign_no_extra", {31'd0, done}, 32'd0);
            @(negedge clk);
        end

        // start held through DONE: back-to-back acceptance
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (32) @(negedge clk);
        start = 1'b1; op = OP_REMU; a = 32'd100; b = 32'd7;
        check("b2b_done1", {31'd0, done}, 32'd1);
        check("b2b_result1", result, 32'd14);
        @(posedge clk);
        #1;
        start = 1'b0; a = '0; b = '0;
        @(negedge clk);
        wait_done("b2b_second", 1'b0, 32'd2);
        @(negedge clk);
        check("b2b_pulse", {31'd0, done}, 32'd0);

        // reset at T+5 aborts; result clears and no done follows
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        rst = 1'b0;
        repeat (40) begin
            check("abort_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        run_op("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
